// File: rtl/rat_int_ctrl_pkg.sv
// Shared types and constants for the RAT MCU interrupt controller.
// Holds the FSM state type, default port IDs and the lowest-index priority helper.
package rat_int_pkg;

  localparam int EOI_W = 3;

  localparam logic [7:0] ID_STATUS_DEF = 8'h30;
  localparam logic [7:0] ID_MASK_DEF   = 8'h31;
  localparam logic [7:0] ID_PEND_DEF   = 8'h32;
  localparam logic [7:0] ID_EOI_DEF    = 8'h33;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } int_state_t;

  // Index of the lowest set bit; source 0 has the highest priority.
  function automatic logic [EOI_W-1:0] lowest_set(input logic [7:0] v);
    lowest_set = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = EOI_W'(i);
    end
  endfunction

endpackage

// File: rtl/rat_int_ctrl_if.sv
// MCU port-space bus: the CPU writes through port_id/out_port/io_strb and
// reads rd_data, with rd_hit selecting this block in the IN_PORT mux.
interface rat_int_ctrl_if;
  logic [7:0] port_id;
  logic [7:0] out_port;
  logic       io_strb;
  logic [7:0] rd_data;
  logic       rd_hit;

  modport master (output port_id, output out_port, output io_strb,
                  input  rd_data, input  rd_hit);
  modport slave  (input  port_id, input  out_port, input  io_strb,
                  output rd_data, output rd_hit);
endinterface

// File: rtl/rat_int_ctrl_irq_sync_edge.sv
// Per-bit 2-FF synchroniser for asynchronous IRQ lines, plus a history flop
// so a one-cycle rise pulse is produced for each low-to-high transition.
module irq_sync_edge #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] rise
);

  logic [WIDTH-1:0] s1, s2, s3;

  // NOTE: non-blocking assignments make the three flops a true shift chain;
  // blocking ones would collapse it into a single stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= async_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;

endmodule

// File: rtl/rat_int_ctrl.sv
// RAT MCU interrupt controller: edge-latched pending bits, enable mask,
// lowest-index priority and a REQ/GAP handshake retired by an EOI write.
module rat_int_ctrl
  import rat_int_pkg::*;
#(
  parameter int         N_SRC     = 8,
  parameter logic [7:0] ID_STATUS = ID_STATUS_DEF,
  parameter logic [7:0] ID_MASK   = ID_MASK_DEF,
  parameter logic [7:0] ID_PEND   = ID_PEND_DEF,
  parameter logic [7:0] ID_EOI    = ID_EOI_DEF
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_SRC-1:0]     irq,
  rat_int_ctrl_if.slave        bus,
  output logic                 int_cu
);

  logic [N_SRC-1:0] mask, pend, rise, clr, pend_en;
  logic [7:0]       pend_ext;
  logic [EOI_W-1:0] cur_id, next_id, eoi_idx;
  logic             wr_mask, wr_pend, eoi_ok;
  int_state_t       state, state_nx;

  irq_sync_edge #(.WIDTH(N_SRC)) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (irq),
    .rise     (rise)
  );

  assign wr_mask = bus.io_strb && (bus.port_id == ID_MASK);
  assign wr_pend = bus.io_strb && (bus.port_id == ID_PEND);
  assign eoi_idx = bus.out_port[EOI_W-1:0];
  // The whole byte is range-checked, so e.g. 8'h09 never aliases onto source 1.
  assign eoi_ok  = bus.io_strb && (bus.port_id == ID_EOI) && (bus.out_port < 8'(N_SRC));

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    clr = '0;
    if (wr_pend) clr = bus.out_port[N_SRC-1:0];
    if (eoi_ok)  clr[eoi_idx] = 1'b1;
  end

  assign pend_en = pend & mask;

  always_comb begin
    pend_ext = '0;
    pend_ext[N_SRC-1:0] = pend_en;
  end

  assign next_id = lowest_set(pend_ext);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|pend_en) state_nx = REQ;
      REQ:     if (eoi_ok && (eoi_idx == cur_id)) state_nx = GAP;
      GAP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask   <= '0;
      pend   <= '0;
      cur_id <= '0;
      state  <= IDLE;
      int_cu <= 1'b0;
    end else begin
      if (wr_mask) mask <= bus.out_port[N_SRC-1:0];
      // A fresh rise beats a clear of the same bit in the same cycle.
      pend  <= (pend & ~clr) | rise;
      if ((state == IDLE) && (|pend_en)) cur_id <= next_id;
      state  <= state_nx;
      int_cu <= (state_nx == REQ);
    end
  end

  always_comb begin
    bus.rd_data = 8'h00;
    bus.rd_hit  = 1'b0;
    case (bus.port_id)
      ID_STATUS: begin
        bus.rd_hit  = 1'b1;
        bus.rd_data = {(state == REQ), 4'b0000, cur_id};
      end
      ID_MASK: begin
        bus.rd_hit = 1'b1;
        bus.rd_data[N_SRC-1:0] = mask;
      end
      ID_PEND: begin
        bus.rd_hit = 1'b1;
        bus.rd_data[N_SRC-1:0] = pend;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rat_int_ctrl.sv
// Self-checking bench for rat_int_ctrl: a cycle-level behavioural model checked
// every cycle, plus directed scenarios with hand-computed register values.
module tb_rat_int_ctrl;

  localparam int N = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] irq = 8'h00;
  logic       int_cu;

  rat_int_ctrl_if bus();

  rat_int_ctrl #(.N_SRC(N)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .irq     (irq),
    .bus     (bus),
    .int_cu  (int_cu)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %02h expected %02h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: irq history, pending/mask bytes, "serving" and "cooldown" flags.
  logic [7:0] h0 = '0, h1 = '0, h2 = '0;
  logic [7:0] m_mask = '0, m_pend = '0;
  logic [2:0] m_cur = '0;
  bit         m_busy = 0, m_gap = 0;

  task automatic model_reset();
    h0 = '0; h1 = '0; h2 = '0;
    m_mask = '0; m_pend = '0; m_cur = '0;
    m_busy = 0; m_gap = 0;
  endtask

  task automatic model_step();
    logic [7:0] rise, clr, ready;
    bit eoi, found;
    rise = h1 & ~h2;
    h2 = h1; h1 = h0; h0 = irq;
    eoi   = bus.io_strb && (bus.port_id == 8'h33) && (bus.out_port < 8'(N));
    ready = m_pend & m_mask;
    if (m_busy) begin
      if (eoi && (bus.out_port[2:0] == m_cur)) begin
        m_busy = 0;
        m_gap  = 1;
      end
    end else if (m_gap) begin
      m_gap = 0;
    end else if (ready != 8'h00) begin
      m_busy = 1;
      found  = 0;
      for (int i = 0; i < N; i++) begin
        if (ready[i] && !found) begin
          m_cur = 3'(i);
          found = 1;
        end
      end
    end
    clr = 8'h00;
    if (bus.io_strb && (bus.port_id == 8'h31)) m_mask = bus.out_port;
    if (bus.io_strb && (bus.port_id == 8'h32)) clr = bus.out_port;
    if (eoi) clr[bus.out_port[2:0]] = 1'b1;
    m_pend = (m_pend & ~clr) | rise;
  endtask

  task automatic model_read(input logic [7:0] id, output logic [7:0] d, output logic hit);
    d   = 8'h00;
    hit = 1'b1;
    case (id)
      8'h30:   d = {m_busy, 4'b0000, m_cur};
      8'h31:   d = m_mask;
      8'h32:   d = m_pend;
      default: hit = 1'b0;
    endcase
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) model_reset();
    else          model_step();
  end

  always @(negedge clk) begin : cmp
    logic [7:0] d;
    logic       h;
    model_read(bus.port_id, d, h);
    check("cyc_int_cu",  {7'b0, int_cu},     {7'b0, m_busy});
    check("cyc_rd_data", bus.rd_data,        d);
    check("cyc_rd_hit",  {7'b0, bus.rd_hit}, {7'b0, h});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] id, input logic [7:0] d);
    @(posedge clk); #1;
    bus.port_id  = id;
    bus.out_port = d;
    bus.io_strb  = 1'b1;
    @(posedge clk); #1;
    bus.io_strb  = 1'b0;
    bus.port_id  = 8'h00;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] id, input logic [7:0] exp);
    @(negedge clk); #1;
    bus.port_id = id;
    #1;
    check(name, bus.rd_data, exp);
  endtask

  task automatic wait_int(input logic lvl, input int budget, input string name, output int n);
    n = 0;
    while ((int_cu !== lvl) && (n < budget)) begin
      @(posedge clk); #1;
      n++;
    end
    check(name, {7'b0, int_cu}, {7'b0, lvl});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.port_id  = 8'h00;
    bus.out_port = 8'h00;
    bus.io_strb  = 1'b0;

    // 1 Reset
    tick(2);
    check("rst_int_cu", {7'b0, int_cu}, 8'h00);
    rd_chk("rst_status", 8'h30, 8'h00);
    rd_chk("rst_mask",   8'h31, 8'h00);
    rd_chk("rst_pend",   8'h32, 8'h00);
    rd_chk("unmapped",   8'h40, 8'h00);
    check("unmapped_hit", {7'b0, bus.rd_hit}, 8'h00);
    tick(1);
    reset_n = 1'b1;
    wr(8'h30, 8'hFF);
    rd_chk("status_wr_ignored", 8'h30, 8'h00);
    rd_chk("status_wr_mask",    8'h31, 8'h00);
    check("mask_hit", {7'b0, bus.rd_hit}, 8'h01);

    // 2 Basic request and EOI
    wr(8'h31, 8'h01);
    irq = 8'h01;
    wait_int(1'b1, 10, "basic_int", n);
    check("basic_latency", 8'(n), 8'd4);
    irq = 8'h00;
    rd_chk("basic_status", 8'h30, 8'h80);
    wr(8'h33, 8'h00);
    check("basic_eoi_drop", {7'b0, int_cu}, 8'h00);
    tick(3);
    check("basic_stays_low", {7'b0, int_cu}, 8'h00);
    rd_chk("basic_pend", 8'h32, 8'h00);
    rd_chk("basic_idle_status", 8'h30, 8'h00);

    // 3 Priority between two simultaneous rises
    wr(8'h31, 8'hFF);
    irq = 8'h24;
    wait_int(1'b1, 10, "prio_int", n);
    irq = 8'h00;
    rd_chk("prio_first", 8'h30, 8'h82);
    wr(8'h33, 8'h02);
    check("prio_gap", {7'b0, int_cu}, 8'h00);
    wait_int(1'b1, 6, "prio_second_int", n);
    check("prio_gap_len", 8'(n), 8'd2);
    rd_chk("prio_second", 8'h30, 8'h85);
    wr(8'h33, 8'h05);
    tick(3);
    check("prio_done", {7'b0, int_cu}, 8'h00);
    rd_chk("prio_idle_status", 8'h30, 8'h05);

    // 4 Masked sources still latch; W1C; unmask fires
    wr(8'h31, 8'h00);
    irq = 8'h48;
    tick(2);
    irq = 8'h00;
    tick(3);
    rd_chk("masked_pend", 8'h32, 8'h48);
    check("masked_no_int", {7'b0, int_cu}, 8'h00);
    wr(8'h32, 8'h40);
    rd_chk("w1c_pend", 8'h32, 8'h08);
    wr(8'h31, 8'h08);
    wait_int(1'b1, 6, "unmask_int", n);
    rd_chk("unmask_status", 8'h30, 8'h83);
    wr(8'h33, 8'h03);
    tick(3);

    // 5 Boundaries: wrong EOI, out-of-range EOI, set beats W1C
    wr(8'h31, 8'h02);
    irq = 8'h02;
    tick(2);
    irq = 8'h00;
    wait_int(1'b1, 6, "bnd_int", n);
    rd_chk("bnd_status", 8'h30, 8'h81);
    wr(8'h33, 8'h04);
    check("wrong_eoi_int", {7'b0, int_cu}, 8'h01);
    rd_chk("wrong_eoi_status", 8'h30, 8'h81);
    wr(8'h33, 8'h09);
    check("eoi09_int", {7'b0, int_cu}, 8'h01);
    rd_chk("eoi09_status", 8'h30, 8'h81);
    rd_chk("eoi09_pend",   8'h32, 8'h02);
    tick(1);
    irq = 8'h02;
    tick(1);
    wr(8'h32, 8'h02);
    rd_chk("set_beats_w1c", 8'h32, 8'h02);
    wr(8'h33, 8'h01);
    check("bnd_eoi_drop", {7'b0, int_cu}, 8'h00);
    irq = 8'h00;
    tick(3);
    check("bnd_idle", {7'b0, int_cu}, 8'h00);
    rd_chk("bnd_pend_clear", 8'h32, 8'h00);

    // 6 Asynchronous reset while in REQ
    wr(8'h31, 8'h01);
    irq = 8'h01;
    wait_int(1'b1, 10, "arst_int", n);
    irq = 8'h00;
    @(posedge clk); #3;
    reset_n = 1'b0;
    #1;
    check("arst_drop", {7'b0, int_cu}, 8'h00);
    tick(2);
    reset_n = 1'b1;
    rd_chk("arst_status", 8'h30, 8'h00);
    rd_chk("arst_mask",   8'h31, 8'h00);
    rd_chk("arst_pend",   8'h32, 8'h00);
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
